// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid bus, and hands {pc, instr} to decode via a registered valid/ready.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_ro,
  input  logic        ready_i
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        buf_v_q, buf_v_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  logic cke, gnt, resp, inflight_after;
  logic unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];

  assign cke         = ~valid_q | ready_i;
  assign imem_req_o  = (state_q == S_REQ) & ~buf_v_q & rst;
  assign imem_addr_o = pc_q;
  assign gnt         = imem_req_o & imem_gnt_i;
  assign resp        = (state_q == S_WAIT) & imem_rvalid_i;

  // A request is still in flight after this edge if its response has not shown up yet.
  assign inflight_after = ((state_q == S_WAIT) & ~imem_rvalid_i)
                        | ((state_q == S_REQ)  & gnt)
                        | ((state_q == S_DROP) & ~imem_rvalid_i);

  assign valid_ro = valid_q;
  assign pc_o     = out_pc_q;
  assign instr_o  = out_instr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    valid_d     = valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    buf_v_d     = buf_v_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    if (redirect_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      valid_d = 1'b0;
      buf_v_d = 1'b0;
      state_d = inflight_after ? S_DROP : S_REQ;
    end else begin
      // Skid buffer drains ahead of any fresh response to keep program order.
      if (cke) begin
        if (buf_v_q) begin
          valid_d     = 1'b1;
          out_pc_d    = buf_pc_q;
          out_instr_d = buf_instr_q;
          buf_v_d     = 1'b0;
        end else if (resp) begin
          valid_d     = 1'b1;
          out_pc_d    = req_pc_q;
          out_instr_d = imem_rdata_i;
        end else begin
          valid_d     = 1'b0;
        end
      end
      if (resp && !(cke && !buf_v_q)) begin
        buf_v_d     = 1'b1;
        buf_pc_d    = req_pc_q;
        buf_instr_d = imem_rdata_i;
      end

      case (state_q)
        S_REQ: if (gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
        S_WAIT:  if (imem_rvalid_i) state_d = S_REQ;
        S_DROP:  if (imem_rvalid_i) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      valid_q     <= 1'b0;
      out_pc_q    <= 32'h0;
      out_instr_q <= 32'h0;
      buf_v_q     <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      valid_q     <= valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      buf_v_q     <= buf_v_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboarded bench for ifetch: a memory responder, a directed+random driver,
// and a monitor that checks every decode handshake against the expected PC stream.
module tb_ifetch;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] pc_o, instr_o;
  logic        valid_ro;
  logic        ready_i = 1'b0;

  ifetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .instr_o(instr_o), .valid_ro(valid_ro), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int hs_t[$];
  int hs_total = 0;

  // memory behaviour knobs
  bit gnt_always = 1'b1;
  int kfix = 1;
  bit pend = 1'b0;
  int cnt = 0;
  logic [31:0] paddr = 32'h0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream after reset/redirect: contiguous words from the start PC.
  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back({start[31:2], 2'b00} + 32'(4 * i));
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every accepted instruction must be the next one the model expects.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_ro && ready_i) begin
        hs_t.push_back(cyc);
        hs_total++;
        if (exp_q.size() == 0) begin
          vectors++; errs++;
          $display("FAIL unexpected_instr: got pc %h with empty scoreboard", pc_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("pc_o", pc_o, e);
          chk("instr_o", instr_o, memfn(e));
        end
      end
    end
  end

  // Memory: grants (always or random), answers each grant k>=1 cycles later, in order.
  initial begin
    bit f, rf, rs;
    logic [31:0] fa;
    forever begin
      @(negedge clk);
      f = imem_req_o & imem_gnt_i; fa = imem_addr_o; rf = imem_rvalid_i; rs = rst;
      @(posedge clk); #1;
      if (!rs) pend = 1'b0;
      else begin
        if (rf) pend = 1'b0;
        if (f) begin
          pend = 1'b1; paddr = fa;
          cnt = (kfix != 0) ? kfix - 1 : int'($urandom_range(0, 3));
        end else if (pend) cnt--;
      end
      imem_rvalid_i = pend && (cnt == 0);
      imem_rdata_i  = imem_rvalid_i ? memfn(paddr) : $urandom;
      imem_gnt_i    = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_i = 1'b1; redirect_pc_i = t;
    @(posedge clk);
    model_restart(t);
    #2;
    redirect_i = 1'b0; redirect_pc_i = $urandom;
    chk("valid_after_redirect", {31'b0, valid_ro}, 32'h0);
  endtask

  task automatic wait_req_addr(input string name, input logic [31:0] exp);
    int n = 0;
    while (!imem_req_o && n < 200) begin step(1); n++; end
    if (!imem_req_o) begin
      vectors++; errs++;
      $display("FAIL %s: no request within 200 cycles, expected addr %h", name, exp);
    end else chk(name, imem_addr_o, exp);
  endtask

  task automatic wait_wait_state();
    int n = 0;
    while (!(pend && cnt >= 1) && n < 200) begin step(1); n++; end
    if (!(pend && cnt >= 1)) begin
      vectors++; errs++;
      $display("FAIL wait_state_timeout: got none expected outstanding request");
    end
  endtask

  initial begin
    // reset values
    step(3);
    chk("rst_valid", {31'b0, valid_ro}, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_instr_o", instr_o, 32'h0);
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    model_restart(RPC);
    ready_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("first_req", {31'b0, imem_req_o}, 32'h1);
    chk("first_addr", imem_addr_o, RPC);
    #1;

    // streaming at peak rate: one instruction every 2 cycles
    step(12);
    if (hs_t.size() < 3) chk("stream_count", 32'(hs_t.size()), 32'd3);
    else begin
      chk("stream_gap0", 32'(hs_t[1] - hs_t[0]), 32'd2);
      chk("stream_gap1", 32'(hs_t[2] - hs_t[1]), 32'd2);
    end

    // decode stall: output held, skid buffer full, no requests
    ready_i = 1'b0;
    step(6);
    chk("stall_valid", {31'b0, valid_ro}, 32'h1);
    chk("stall_pc_held", pc_o, exp_q[0]);
    chk("stall_req_off", {31'b0, imem_req_o}, 32'h0);
    chk("stall_next_fetch", imem_addr_o, exp_q[0] + 32'd8);
    ready_i = 1'b1;
    step(10);

    // redirect while waiting on a slow response
    kfix = 3;
    wait_wait_state();
    do_redirect(32'h200);
    wait_req_addr("redir_wait_addr", 32'h200);
    step(20);

    // redirect in the same cycle as a grant: response must be dropped
    kfix = 1;
    wait_req_addr("pre_grant_req", imem_addr_o);
    do_redirect(32'h400);
    chk("drop_no_req", {31'b0, imem_req_o}, 32'h0);
    wait_req_addr("drop_next_addr", 32'h400);
    step(10);

    // misaligned redirect target and PC wrap-around
    do_redirect(32'h203);
    wait_req_addr("align_addr", 32'h200);
    step(8);
    do_redirect(32'hFFFF_FFF8);
    step(12);

    // asynchronous reset in the middle of a wait
    kfix = 3;
    wait_wait_state();
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, valid_ro}, 32'h0);
    chk("midrst_pc_o", pc_o, 32'h0);
    chk("midrst_instr_o", instr_o, 32'h0);
    chk("midrst_req", {31'b0, imem_req_o}, 32'h0);
    step(2);
    model_restart(RPC);
    rst = 1'b1;
    #1;
    chk("rerst_addr", imem_addr_o, RPC);
    #1;
    step(15);

    // random traffic: random grants, latencies, back-pressure and redirects
    kfix = 0;
    gnt_always = 1'b0;
    hs_total = 0;
    for (int i = 0; i < 3000; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) do_redirect($urandom);
      else step(1);
    end
    ready_i = 1'b1;
    step(20);
    vectors++;
    if (hs_total < 200) begin
      errs++;
      $display("FAIL random_progress: got %0d handshakes expected at least 200", hs_total);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end
endmodule
